// File: rtl/seg_scan_driver_if.sv
// Bus bundle for the seven-segment scan driver: control/data inputs and
// the registered segment/anode outputs.
interface seg_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic                  hex_mode;
  logic                  lz_blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output en, load, data, dp_in, hex_mode, lz_blank,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, load, data, dp_in, hex_mode, lz_blank,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. A prescaler paces the digit index;
// new data is double-buffered and only swapped in at the frame wrap so a
// frame never mixes old and new values. All display outputs are registered
// and active-low.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  wrap;

  logic [4*DIGITS-1:0]   pend_data;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_v;
  logic [4*DIGITS-1:0]   act_data;
  logic [DIGITS-1:0]     act_dp;

  logic [3:0]            nib;
  logic                  lead_zero;
  logic [6:0]            glyph;

  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [DIGITS-1:0]     an_r;
  logic                  frame_done_r;

  assign tick = bus.en && (cnt == CW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  // Prescaler and digit index; both freeze while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (bus.en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: loads land in pending; pending moves to active only at a
  // wrap, and a load on the wrap cycle itself waits for the next wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_v    <= 1'b0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (wrap && pend_v) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
      if (bus.load) begin
        pend_data <= bus.data;
        pend_dp   <= bus.dp_in;
        pend_v    <= 1'b1;
      end else if (wrap) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Glyph decode for the current digit, including live hex and
  // leading-zero blanking (digit 0 is never blanked).
  always_comb begin
    nib       = act_data[4*int'(idx) +: 4];
    lead_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && act_data[4*j +: 4] != 4'h0)
        lead_zero = 1'b0;
    end
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    if (nib >= 4'hA && !bus.hex_mode)
      glyph = 7'h7F;
    if (bus.lz_blank && idx != '0 && lead_zero)
      glyph = 7'h7F;
  end

  // Registered display outputs, blanked while disabled, plus the frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      an_r         <= '1;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap;
      if (bus.en) begin
        seg_r <= glyph;
        dp_r  <= ~act_dp[idx];
        an_r  <= ~(DIGITS'(1) << idx);
      end else begin
        seg_r <= 7'h7F;
        dp_r  <= 1'b1;
        an_r  <= '1;
      end
    end
  end

  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.an         = an_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is driven (legal range >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-005 The block SHALL have port en, input, 1, scan enable.
REQ-006 The block SHALL have port load, input, 1, a request to capture data and dp_in.
REQ-007 The block SHALL have port data, input, 4*DIGITS, the digit nibbles; nibble i = data[4i+3:4i], and digit 0 is least significant.
REQ-008 The block SHALL have port dp_in, input, DIGITS, the decimal point request per digit, active-high.
REQ-009 The block SHALL have port hex_mode, input, 1, selecting hexadecimal glyphs for nibbles 10..15 when 1.
REQ-010 The block SHALL have port lz_blank, input, 1, enabling leading-zero suppression.
REQ-011 The block SHALL have port seg, output, 7, the segments gfedcba (seg[6]=g, seg[0]=a), active-low.
REQ-012 The block SHALL have port dp, output, 1, the decimal point segment, active-low.
REQ-013 The block SHALL have port an, output, DIGITS, the digit anodes, active-low one-hot.
REQ-014 The block SHALL have port frame_done, output, 1, a one-cycle pulse at the end of each full scan.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 while en=1 and wrap to 0; tick is asserted when the count equals SCAN_DIV-1.
REQ-016 On tick, the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0.
REQ-017 frame_done SHALL pulse high for exactly the one cycle after a tick that wraps the index to 0.
REQ-018 While en=0, the prescaler and index SHALL hold their values, an SHALL be all 1, seg SHALL be 7'h7F, and dp SHALL be 1.
REQ-019 A cycle with load=1 SHALL capture data and dp_in into a pending register and set pend_v; with repeated loads, the latest load wins.
REQ-020 The pending register SHALL be copied into the active register, and pend_v cleared, on a wrapping tick (REQ-016) when pend_v=1 at that edge.
REQ-021 A load coinciding with a wrapping tick SHALL go to pending only and be applied at the next wrap, so no frame ever mixes old and new values.
REQ-022 seg, dp and an SHALL be registered and reflect the current index and active register one cycle after the index changes (latency 1).
REQ-023 an SHALL drive bit idx low and all other bits high.
REQ-024 Glyphs for nibbles 0..9 SHALL be 40,79,24,30,19,12,02,78,00,10 (hex, 7-bit active-low).
REQ-025 For nibbles 10..15: if hex_mode=1, the glyphs SHALL be A=08, b=03, C=46, d=21, E=06, F=0E; if hex_mode=0, seg SHALL be 7F (blank).
REQ-026 With lz_blank=1, digit i>0 SHALL show seg=7F when nibbles DIGITS-1..i of the active register are all zero; digit 0 SHALL never be suppressed.
REQ-027 dp SHALL be the inverse of the active dp bit for the current index; dp is not affected by lz_blank.
REQ-028 hex_mode and lz_blank SHALL be sampled live, not latched by load.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately clear the prescaler, index, and active and pending registers; it SHALL clear pend_v; and it SHALL set frame_done=0, an all 1, seg=7F and dp=1.
REQ-030 On the first rising edge after rst_n is released, the block SHALL begin scanning from digit 0 with prescaler 0.
REQ-031 Reset mid-frame SHALL discard any pending load.

Verification
REQ-032 Scan test: DIGITS=4, SCAN_DIV=4, en=1 -> an sequence 1110,1101,1011,0111 with each value held for 4 cycles; frame_done pulses once every 16 cycles.
REQ-033 Load test: load data=16'h1234 mid-frame -> display unchanged until the wrap; the next frame shows 4,3,2,1 on digits 0..3 (seg 19,30,24,79).
REQ-034 Hex test: data nibble 4'hB with hex_mode=1 -> seg=03; with hex_mode=0 -> seg=7F.
REQ-035 Leading-zero test: data=16'h0050 with lz_blank=1 -> digits 3 and 2 show 7F, digit 1 shows 12, digit 0 shows 40; data=16'h0000 -> only digit 0 shows 40.
REQ-036 Enable/reset test: en=0 for 10 cycles -> an=F, index frozen, and the scan resumes at the same index; async rst_n pulse mid-frame -> outputs reach reset values without waiting for a clock edge, and the pending load is lost.
REQ-037 Collision test: load asserted on the wrapping tick cycle -> the new value appears only after the following wrap.
